// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - arb_state_e : arbiter FSM encoding (normal sharing vs. exclusive EXT ownership)
//   - mem_req_t   : one memory-port request {re, we, addr, wdata}
//   - defaults for the starvation limit and request field widths
package dmem_arbiter_pkg;

  typedef enum logic {
    ARB_RUN    = 1'b0,
    ARB_HALTED = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_WAIT_DEF = 8;
  // Wide enough for any MAX_WAIT in 1..255.
  localparam int ARB_WAIT_W       = 8;
  localparam int ARB_ADDR_W       = 32;
  localparam int ARB_DATA_W       = 32;

  typedef struct packed {
    logic                  re;
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   clr_i      : clear to 0 this edge (wins over inc_i)
//   inc_i      : increment by one, holding at LIMIT
//   cnt_o      : current count
module arb_sat_counter #(
  parameter int           W     = 8,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the pipeline MEM stage (CPU, fixed
// priority) and an external loader/debug master (EXT).
//   CPU side : cpu_re/we/addr/wdata in, cpu_rdata out, cpu_stall out
//   EXT side : ext_valid/we/addr/wdata in, ext_ready out,
//              ext_rvalid/ext_rdata out (registered, 1-cycle latency)
//   Halt     : ext_halt in requests exclusive EXT ownership, halted out
//   Memory   : mem_addr/wdata/re/we out, mem_rdata in (combinational read)
//   Stats    : stall_cnt, saturating count of arbiter-caused stall cycles
// EXT wins idle CPU cycles, and after MAX_WAIT denied cycles it takes one
// forced slot in which the CPU is stalled (its access is delayed, not lost).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = ARB_MAX_WAIT_DEF,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_valid,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ready,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_halt,
  output logic              halted,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] stall_cnt
);

  localparam logic [ARB_WAIT_W-1:0] WAIT_LIMIT = ARB_WAIT_W'(MAX_WAIT);

  arb_state_e            state_q, state_d;
  logic                  ext_rvalid_q, ext_rvalid_d;
  logic [DATA_W-1:0]     ext_rdata_q, ext_rdata_d;
  logic [ARB_WAIT_W-1:0] wait_cnt;
  logic                  cpu_act;
  logic                  ext_fire;
  logic                  wait_clr, wait_inc;
  mem_req_t              req;

  assign cpu_act = cpu_re | cpu_we;
  assign halted  = (state_q == ARB_HALTED);

  // Grant, stall, port mux and next state.
  always_comb begin
    state_d  = state_q;
    ext_fire = 1'b0;
    cpu_stall = 1'b0;
    wait_clr = 1'b1;
    wait_inc = 1'b0;
    // Default: port follows the CPU, so an idle port has re=we=0 and
    // address/data tracking the MEM stage.
    req.re    = cpu_re;
    req.we    = cpu_we;
    req.addr  = ARB_ADDR_W'(cpu_addr);
    req.wdata = ARB_DATA_W'(cpu_wdata);

    case (state_q)
      ARB_RUN: begin
        ext_fire  = ext_valid & (~cpu_act | (wait_cnt == WAIT_LIMIT));
        cpu_stall = ext_fire & cpu_act;
        wait_inc  = ext_valid & ~ext_fire;
        wait_clr  = ~ext_valid | ext_fire;
        if (ext_halt) state_d = ARB_HALTED;
      end
      ARB_HALTED: begin
        ext_fire  = ext_valid;
        cpu_stall = 1'b1;
        req.re    = 1'b0;
        req.we    = 1'b0;
        if (!ext_halt) state_d = ARB_RUN;
      end
      default: state_d = ARB_RUN;
    endcase

    if (ext_fire) begin
      req.re    = ~ext_we;
      req.we    = ext_we;
      req.addr  = ARB_ADDR_W'(ext_addr);
      req.wdata = ARB_DATA_W'(ext_wdata);
    end

    ext_rvalid_d = ext_fire & ~ext_we;
    ext_rdata_d  = (ext_fire & ~ext_we) ? mem_rdata : ext_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_RUN;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  arb_sat_counter #(
    .W     (ARB_WAIT_W),
    .LIMIT (WAIT_LIMIT)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (wait_clr),
    .inc_i (wait_inc),
    .cnt_o (wait_cnt)
  );

  arb_sat_counter #(
    .W     (STAT_W),
    .LIMIT ({STAT_W{1'b1}})
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (1'b0),
    .inc_i (cpu_stall),
    .cnt_o (stall_cnt)
  );

  assign mem_re     = req.re;
  assign mem_we     = req.we;
  assign mem_addr   = ADDR_W'(req.addr);
  assign mem_wdata  = DATA_W'(req.wdata);
  assign cpu_rdata  = mem_rdata;
  assign ext_ready  = ext_fire;
  assign ext_rvalid = ext_rvalid_q;
  assign ext_rdata  = ext_rdata_q;

  // A MEM stage issuing load and store together is a pipeline bug; it is
  // passed through unchanged.
  a_no_rw_collision : assert property (@(posedge clk) disable iff (reset)
    !(cpu_re && cpu_we));

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_valid, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_ready, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        ext_halt, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we;
  logic [15:0] stall_cnt;

  // Second instance with a 4-bit statistics counter, fed the same stimulus.
  logic [31:0] s_cpu_rdata, s_ext_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic        s_cpu_stall, s_ext_ready, s_ext_rvalid, s_halted, s_mem_re, s_mem_we;
  logic [3:0]  s_stall_cnt;

  logic [31:0] mem [0:255];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mem_rdata   = mem[mem_addr[9:2]];
  assign s_mem_rdata = mem[s_mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ready(ext_ready), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ext_halt(ext_halt), .halted(halted),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  dmem_arbiter #(.STAT_W(4)) dut_s (
    .clk(clk), .reset(reset),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
    .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ready(s_ext_ready), .ext_rvalid(s_ext_rvalid), .ext_rdata(s_ext_rdata),
    .ext_halt(ext_halt), .halted(s_halted),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_re(s_mem_re), .mem_we(s_mem_we),
    .mem_rdata(s_mem_rdata), .stall_cnt(s_stall_cnt)
  );

  // Advance to just after the next rising edge; inputs change here and
  // outputs are sampled a few ns later, well before the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_valid = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0; ext_halt = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
    n_cmp++; if (ext_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got %b want 0", ext_rvalid); end
    n_cmp++; if (ext_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", ext_rdata); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_cpu_stall got %b want 0", cpu_stall); end
  endtask

  task automatic test_cpu_only();
    cpu_re = 1; cpu_addr = 32'h10;
    #3;
    n_cmp++; if (cpu_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL cpu_load_data got %h want deadbeef", cpu_rdata); end
    n_cmp++; if (mem_re !== 1'b1 || mem_addr !== 32'h10) begin n_err++; $display("FAIL cpu_load_port got re=%b addr=%h want re=1 addr=10", mem_re, mem_addr); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL cpu_load_stall got %b want 0", cpu_stall); end
    step();
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL cpu_load_stall_cnt got %0d want 0", stall_cnt); end
    // Idle port tracks the CPU address with no strobes.
    cpu_re = 0; cpu_addr = 32'h44; cpu_wdata = 32'hCAFE0001;
    #3;
    n_cmp++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL idle_strobes got re=%b we=%b want 0 0", mem_re, mem_we); end
    n_cmp++; if (mem_addr !== 32'h44 || mem_wdata !== 32'hCAFE0001) begin n_err++; $display("FAIL idle_follow got addr=%h wdata=%h want 44 cafe0001", mem_addr, mem_wdata); end
    step();
  endtask

  task automatic test_ext_free();
    idle_inputs();
    ext_valid = 1; ext_we = 1; ext_addr = 32'h20; ext_wdata = 32'h12345678;
    #3;
    n_cmp++; if (ext_ready !== 1'b1) begin n_err++; $display("FAIL ext_wr_ready got %b want 1", ext_ready); end
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin n_err++; $display("FAIL ext_wr_port got we=%b addr=%h data=%h", mem_we, mem_addr, mem_wdata); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL ext_wr_stall got %b want 0", cpu_stall); end
    step();
    ext_we = 0;
    #3;
    n_cmp++; if (ext_ready !== 1'b1 || mem_re !== 1'b1) begin n_err++; $display("FAIL ext_rd_ready got ready=%b re=%b want 1 1", ext_ready, mem_re); end
    n_cmp++; if (ext_rvalid !== 1'b0) begin n_err++; $display("FAIL ext_wr_no_resp got %b want 0", ext_rvalid); end
    step();
    ext_valid = 0;
    #3;
    n_cmp++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h12345678) begin n_err++; $display("FAIL ext_rd_resp got v=%b d=%h want 1 12345678", ext_rvalid, ext_rdata); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL ext_rd_stall got %b want 0", cpu_stall); end
    step();
    n_cmp++; if (ext_rvalid !== 1'b0) begin n_err++; $display("FAIL ext_rvalid_pulse got %b want 0", ext_rvalid); end
  endtask

  task automatic test_starvation();
    do_reset();
    cpu_re = 1; cpu_addr = 32'h10;
    ext_valid = 1; ext_we = 0; ext_addr = 32'h20;
    for (int i = 1; i <= 8; i++) begin
      #3;
      n_cmp++; if (ext_ready !== 1'b0 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL starve_cycle%0d got ready=%b stall=%b want 0 0", i, ext_ready, cpu_stall); end
      step();
    end
    #3;
    n_cmp++; if (ext_ready !== 1'b1 || cpu_stall !== 1'b1) begin n_err++; $display("FAIL forced_slot got ready=%b stall=%b want 1 1", ext_ready, cpu_stall); end
    n_cmp++; if (mem_addr !== 32'h20 || mem_re !== 1'b1) begin n_err++; $display("FAIL forced_port got addr=%h re=%b want 20 1", mem_addr, mem_re); end
    step();
    #3;
    n_cmp++; if (ext_ready !== 1'b0 || cpu_stall !== 1'b0 || mem_addr !== 32'h10) begin n_err++; $display("FAIL cpu_after_slot got ready=%b stall=%b addr=%h want 0 0 10", ext_ready, cpu_stall, mem_addr); end
    n_cmp++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h12345678) begin n_err++; $display("FAIL forced_resp got v=%b d=%h want 1 12345678", ext_rvalid, ext_rdata); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL starve_stall_cnt got %0d want 1", stall_cnt); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_halt();
    do_reset();
    cpu_re = 1; cpu_addr = 32'h10; ext_halt = 1;
    #3;
    n_cmp++; if (halted !== 1'b0 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL halt_entry_cycle got halted=%b stall=%b want 0 0", halted, cpu_stall); end
    for (int c = 1; c <= 5; c++) begin
      step();
      ext_valid = (c % 2 == 1);
      ext_we = 1;
      ext_addr = 32'h40 + 32'(c - 1) * 2;
      ext_wdata = 32'hA0 + 32'(c);
      if (c == 5) ext_halt = 0;
      #3;
      n_cmp++; if (halted !== 1'b1 || cpu_stall !== 1'b1) begin n_err++; $display("FAIL halt_cycle%0d got halted=%b stall=%b want 1 1", c, halted, cpu_stall); end
      n_cmp++; if (ext_ready !== ext_valid || mem_we !== ext_valid) begin n_err++; $display("FAIL halt_port%0d got ready=%b we=%b want %b", c, ext_ready, mem_we, ext_valid); end
    end
    step();
    ext_valid = 0;
    #3;
    n_cmp++; if (halted !== 1'b0 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL halt_exit got halted=%b stall=%b want 0 0", halted, cpu_stall); end
    n_cmp++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL halt_stall_cnt got %0d want 5", stall_cnt); end
    n_cmp++; if (mem[16] !== 32'hA1 || mem[17] !== 32'hA3 || mem[18] !== 32'hA5) begin n_err++; $display("FAIL halt_writes got %h %h %h want a1 a3 a5", mem[16], mem[17], mem[18]); end
    step();
    idle_inputs();
  endtask

  task automatic test_reset_in_halted();
    do_reset();
    ext_halt = 1;
    step();
    step();
    ext_valid = 1; ext_we = 0; ext_addr = 32'h20;
    reset = 1;
    #3;
    n_cmp++; if (halted !== 1'b1 || ext_ready !== 1'b1) begin n_err++; $display("FAIL pre_reset_halted got halted=%b ready=%b want 1 1", halted, ext_ready); end
    step();
    reset = 0; ext_halt = 0; ext_valid = 0; cpu_re = 1; cpu_addr = 32'h10;
    #3;
    n_cmp++; if (halted !== 1'b0 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL rst_halt_state got halted=%b stall=%b want 0 0", halted, cpu_stall); end
    n_cmp++; if (ext_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_halt_rvalid got %b want 0", ext_rvalid); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_halt_stall_cnt got %0d want 0", stall_cnt); end
    step();
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    ext_halt = 1;
    step();
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 10) begin
        #3;
        n_cmp++; if (s_stall_cnt !== 4'd10) begin n_err++; $display("FAIL sat_mid got %0d want 10", s_stall_cnt); end
      end
    end
    #3;
    n_cmp++; if (s_stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_hold got %0d want 15", s_stall_cnt); end
    n_cmp++; if (stall_cnt !== 16'd20) begin n_err++; $display("FAIL wide_cnt got %0d want 20", stall_cnt); end
    ext_halt = 0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    reset = 1;
    idle_inputs();
    test_reset();
    test_cpu_only();
    test_ext_free();
    test_starvation();
    test_halt();
    test_reset_in_halted();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
